// File: rtl/tc_io_pad_ctrl.sv
// tc_io_pad_ctrl: per-pad IO config registers, RTE power-up sequencing and output-enable
// turnaround gating. Optional per-pad write lock is built when TC_IO_PAD_CTRL_LOCK_EN is defined.
module tc_io_pad_ctrl #(
  parameter int  NumPads          = 8,
  parameter int  TurnaroundCycles = 2,
  parameter int  RteDelayCycles   = 16,
  localparam int AddrWidth        = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_req_i,
  input  logic                   cfg_we_i,
  input  logic [AddrWidth-1:0]   cfg_addr_i,
  input  logic [7:0]             cfg_wdata_i,
  output logic                   cfg_gnt_o,
  output logic                   cfg_rvalid_o,
  output logic [7:0]             cfg_rdata_o,
  output logic                   rte_o,
  output logic                   ready_o,
  output logic [NumPads-1:0]     io_direction_oe_no,
  output logic [NumPads*4-1:0]   io_driving_strength_o,
  output logic [NumPads-1:0]     io_pullup_en_o,
  output logic [NumPads-1:0]     io_pulldown_en_o
);

  typedef enum logic [0:0] {
    RTE_WAIT = 1'b0,
    ACTIVE   = 1'b1
  } pwr_state_e;

  localparam logic [3:0]  TaLast  = 4'(TurnaroundCycles);
  localparam logic [15:0] RteLast = 16'(RteDelayCycles - 1);

  pwr_state_e         state_q, state_d;
  logic [15:0]        rte_cnt_q, rte_cnt_d;
  logic               rte_q, rte_d;
  logic               ready_q, ready_d;
  logic [7:0]         cfg_q [NumPads];
  logic [7:0]         cfg_d [NumPads];
  logic [3:0]         cnt_q [NumPads];
  logic [3:0]         cnt_d [NumPads];
  logic [NumPads-1:0] oe_no_q, oe_no_d;
  logic               rvalid_q, rvalid_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [31:0]        addr_ext_s;
  logic [7:0]         wdata_s;
  logic [NumPads-1:0] locked_s;
  logic               wr_s, rd_s;

  // Pull-up wins over pull-down; bit 7 is only kept when the lock feature exists.
  function automatic logic [7:0] resolve_wdata(input logic [7:0] w);
`ifdef TC_IO_PAD_CTRL_LOCK_EN
    return {w[7], w[6] & ~w[5], w[5:0]};
`else
    return {w[7] & 1'b0, w[6] & ~w[5], w[5:0]};
`endif
  endfunction

  assign cfg_gnt_o  = cfg_req_i;
  assign wr_s       = cfg_req_i & cfg_we_i;
  assign rd_s       = cfg_req_i & ~cfg_we_i;
  assign addr_ext_s = 32'(cfg_addr_i);
  assign wdata_s    = resolve_wdata(cfg_wdata_i);

  // Per-pad lock status.
  always_comb begin
    locked_s = '0;
    for (int p = 0; p < NumPads; p++) begin
`ifdef TC_IO_PAD_CTRL_LOCK_EN
      locked_s[p] = cfg_q[p][7];
`else
      locked_s[p] = 1'b0;
`endif
    end
  end

  // Power-up FSM next state and registered rte/ready values.
  always_comb begin
    state_d   = state_q;
    rte_cnt_d = rte_cnt_q;
    rte_d     = rte_q;
    ready_d   = ready_q;
    case (state_q)
      RTE_WAIT: begin
        if (rte_cnt_q == RteLast) begin
          state_d   = ACTIVE;
          rte_cnt_d = 16'd0;
          rte_d     = 1'b1;
          ready_d   = 1'b1;
        end else begin
          rte_cnt_d = rte_cnt_q + 16'd1;
        end
      end
      ACTIVE: begin
        rte_d   = 1'b1;
        ready_d = 1'b1;
      end
      default: begin
        state_d   = RTE_WAIT;
        rte_cnt_d = 16'd0;
        rte_d     = 1'b0;
        ready_d   = 1'b0;
      end
    endcase
  end

  // Config register writes, read mux and per-pad drive turnaround.
  always_comb begin
    rvalid_d = cfg_req_i;
    rdata_d  = 8'h00;
    oe_no_d  = '1;
    for (int p = 0; p < NumPads; p++) begin
      if (wr_s && (addr_ext_s == 32'(p)) && !locked_s[p]) begin
        cfg_d[p] = wdata_s;
      end else begin
        cfg_d[p] = cfg_q[p];
      end
      rdata_d = rdata_d | ({8{rd_s && (addr_ext_s == 32'(p))}} & cfg_q[p]);
      // Counter tracks how long the current drive request has been stable.
      if (!((state_q == ACTIVE) && cfg_q[p][0])) begin
        cnt_d[p] = 4'd0;
      end else if (cnt_q[p] == TaLast) begin
        cnt_d[p] = TaLast;
      end else begin
        cnt_d[p] = cnt_q[p] + 4'd1;
      end
      oe_no_d[p] = ~((state_d == ACTIVE) && cfg_d[p][0] && (cnt_d[p] == TaLast));
    end
  end

  // Power FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RTE_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rte_cnt_q <= 16'd0;
      rte_q     <= 1'b0;
      ready_q   <= 1'b0;
      oe_no_q   <= '1;
      rvalid_q  <= 1'b0;
      rdata_q   <= 8'h00;
      for (int p = 0; p < NumPads; p++) begin
        cfg_q[p] <= 8'h00;
        cnt_q[p] <= 4'd0;
      end
    end else begin
      rte_cnt_q <= rte_cnt_d;
      rte_q     <= rte_d;
      ready_q   <= ready_d;
      oe_no_q   <= oe_no_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      for (int p = 0; p < NumPads; p++) begin
        cfg_q[p] <= cfg_d[p];
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  // Strength and pull outputs come straight from the config flops.
  always_comb begin
    io_driving_strength_o = '0;
    io_pullup_en_o        = '0;
    io_pulldown_en_o      = '0;
    for (int p = 0; p < NumPads; p++) begin
      io_driving_strength_o[4*p +: 4] = cfg_q[p][4:1];
      io_pullup_en_o[p]               = cfg_q[p][5];
      io_pulldown_en_o[p]             = cfg_q[p][6];
    end
  end

  assign rte_o              = rte_q;
  assign ready_o            = ready_q;
  assign io_direction_oe_no = oe_no_q;
  assign cfg_rvalid_o       = rvalid_q;
  assign cfg_rdata_o        = rdata_q;

endmodule

// File: tb/tb_tc_io_pad_ctrl.sv
// Directed testbench for tc_io_pad_ctrl (6 pads, turnaround 2, RTE delay 16).
module tb_tc_io_pad_ctrl;
  localparam int NP  = 6;
  localparam int TA  = 2;
  localparam int RTE = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_req, cfg_we;
  logic [2:0]    cfg_addr;
  logic [7:0]    cfg_wdata;
  logic          cfg_gnt, cfg_rvalid;
  logic [7:0]    cfg_rdata;
  logic          rte, ready;
  logic [NP-1:0] oe_no, pu, pd;
  logic [NP*4-1:0] strength;
  logic [7:0]    rd;

  int checks = 0;
  int errors = 0;

  tc_io_pad_ctrl #(.NumPads(NP), .TurnaroundCycles(TA), .RteDelayCycles(RTE)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata),
    .rte_o(rte), .ready_o(ready),
    .io_direction_oe_no(oe_no), .io_driving_strength_o(strength),
    .io_pullup_en_o(pu), .io_pulldown_en_o(pd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    #1 check("wr_gnt", 32'(cfg_gnt), 32'd1);
    @(negedge clk);
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_wdata = 8'h00;
    check("wr_rvalid", 32'(cfg_rvalid), 32'd1);
    check("wr_rdata", 32'(cfg_rdata), 32'd0);
  endtask

  task automatic cfg_read(input logic [2:0] a, output logic [7:0] d);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a;
    @(negedge clk);
    cfg_req = 1'b0;
    check("rd_rvalid", 32'(cfg_rvalid), 32'd1);
    d = cfg_rdata;
  endtask

  initial begin
    rst = 1'b1; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rte", 32'(rte), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_oe", 32'(oe_no), 32'h3F);
    check("rst_str", 32'(strength), 32'd0);
    check("rst_pu", 32'(pu), 32'd0);
    check("rst_pd", 32'(pd), 32'd0);
    check("rst_rvalid", 32'(cfg_rvalid), 32'd0);
    check("rst_rdata", 32'(cfg_rdata), 32'd0);

    // Release reset and set pad2 oe during RTE_WAIT.
    rst = 1'b0;
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 8'h01;
    for (int k = 1; k <= RTE; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("wait_wr_rvalid", 32'(cfg_rvalid), 32'd1);
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_wdata = 8'h00;
      end
      check("pwr_rte", 32'(rte), (k == RTE) ? 32'd1 : 32'd0);
      check("pwr_ready", 32'(ready), (k == RTE) ? 32'd1 : 32'd0);
      check("pwr_oe", 32'(oe_no), 32'h3F);
    end
    @(negedge clk); check("ta_rte1", 32'(oe_no), 32'h3F);
    @(negedge clk); check("ta_rte2", 32'(oe_no), 32'h3B);
    cfg_write(3'd2, 8'h00);
    check("oe2_off", 32'(oe_no), 32'h3F);

    // Pad3 turnaround in ACTIVE.
    cfg_write(3'd3, 8'h01);
    check("p3_t1", 32'(oe_no), 32'h3F);
    @(negedge clk); check("p3_t2", 32'(oe_no), 32'h3F);
    @(negedge clk); check("p3_t3", 32'(oe_no), 32'h37);
    cfg_write(3'd3, 8'h00);
    check("p3_off", 32'(oe_no), 32'h3F);

    // Pull conflict resolution and field mapping.
    cfg_write(3'd0, 8'h6B);
    check("p0_str", 32'(strength), 32'h000005);
    check("p0_pu", 32'(pu), 32'h01);
    check("p0_pd", 32'(pd), 32'h00);
    cfg_read(3'd0, rd);
    check("p0_rd", 32'(rd), 32'h2B);
    cfg_write(3'd0, 8'h40);
    cfg_read(3'd0, rd);
    check("p0_rd2", 32'(rd), 32'h40);
    check("p0_pd2", 32'(pd), 32'h01);
    check("p0_pu2", 32'(pu), 32'h00);
    check("p0_oe", 32'(oe_no), 32'h3F);

    // Toggle 1->0->1 mid-turnaround restarts the count.
    cfg_write(3'd4, 8'h01);
    cfg_write(3'd4, 8'h00);
    cfg_write(3'd4, 8'h01);
    check("tog_t1", 32'(oe_no), 32'h3F);
    @(negedge clk); check("tog_t2", 32'(oe_no), 32'h3F);
    @(negedge clk); check("tog_t3", 32'(oe_no), 32'h2F);

    // Same oe value rewritten keeps the pad driving.
    cfg_write(3'd4, 8'h01);
    check("same_oe1", 32'(oe_no), 32'h2F);
    cfg_write(3'd4, 8'h03);
    check("same_oe2", 32'(oe_no), 32'h2F);
    @(negedge clk); check("same_oe3", 32'(oe_no), 32'h2F);
    check("p4_str", 32'(strength), 32'h010000);

    // Out-of-range addresses.
    cfg_write(3'd7, 8'hFF);
    cfg_write(3'd6, 8'hFF);
    cfg_read(3'd7, rd);
    check("oor_rd", 32'(rd), 32'h00);
    cfg_read(3'd4, rd);
    check("p4_rd", 32'(rd), 32'h03);
    check("oor_pu", 32'(pu), 32'h00);
    check("oor_str", 32'(strength), 32'h010000);
    @(negedge clk);
    check("idle_rvalid", 32'(cfg_rvalid), 32'd0);
    check("idle_rdata", 32'(cfg_rdata), 32'd0);

    // Lock behaviour (or plain writes without the lock feature).
    cfg_write(3'd1, 8'h81);
    cfg_write(3'd1, 8'h00);
    repeat (3) @(negedge clk);
    cfg_read(3'd1, rd);
`ifdef TC_IO_PAD_CTRL_LOCK_EN
    check("lock_rd", 32'(rd), 32'h81);
    check("lock_oe", 32'(oe_no), 32'h2D);
`else
    check("lock_rd", 32'(rd), 32'h00);
    check("lock_oe", 32'(oe_no), 32'h2F);
`endif

    // Asynchronous reset in the middle of a turnaround.
    cfg_write(3'd5, 8'h01);
    #2 rst = 1'b1;
    #1;
    check("arst_rte", 32'(rte), 32'd0);
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_oe", 32'(oe_no), 32'h3F);
    check("arst_str", 32'(strength), 32'd0);
    check("arst_pu", 32'(pu), 32'd0);
    check("arst_pd", 32'(pd), 32'd0);
    check("arst_rvalid", 32'(cfg_rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cfg_read(3'd4, rd);
    check("arst_rd", 32'(rd), 32'h00);
    check("arst_wait", 32'(rte), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
